// File: rtl/adxl362_spi_responder.sv
// adxl362_spi_responder
//   SPI mode-0 slave that emulates the ADXL362 register interface so the
//   accelerometer controller can be exercised with injected X/Y/Z samples.
//
//   Optional build macro: ADXL_RESP_WRITE_EN
//     defined   -> 0x0A write command accepted; 0x1F, 0x2C, 0x2D writable;
//                  soft_reset_pulse live.
//     undefined -> read-only device; 0x0A treated as an unknown command.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   sclk, ss, mosi      SPI pins from the master (asynchronous to clk)
//   miso                SPI data to the master, 0 while deselected
//   sample_x/y/z        12-bit signed samples to present
//   sample_valid        one-cycle strobe capturing sample_x/y/z
//   data_ready          STATUS[0]
//   busy                synchronized ss active
//   soft_reset_pulse    one-cycle pulse on a 0x52 write to SOFT_RESET
//
// FSM
//   state  | meaning
//   IDLE   | deselected, waiting for ss falling edge
//   CMD    | shifting in the command byte
//   ADDR   | shifting in the address byte
//   RDATA  | shifting register bytes out on miso
//   WDATA  | shifting in write data bytes
//   IGNORE | unknown command, rest of the frame is dropped
module adxl362_spi_responder #(
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        ss,
    input  logic        mosi,
    output logic        miso,
    input  logic [11:0] sample_x,
    input  logic [11:0] sample_y,
    input  logic [11:0] sample_z,
    input  logic        sample_valid,
    output logic        data_ready,
    output logic        busy,
    output logic        soft_reset_pulse
);

    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] CMD_WRITE      = 8'h0A;
    localparam logic [7:0] FILTER_CTL_RST = 8'h13;
    localparam logic [7:0] POWER_CTL_RST  = 8'h00;

`ifdef ADXL_RESP_WRITE_EN
    localparam logic WRITE_EN = 1'b1;
`else
    localparam logic WRITE_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, IGNORE} state_t;

    state_t      state, state_nxt;

    logic [1:0]  sclk_s, ss_s, mosi_s;
    logic        sclk_q, ss_q;
    logic [1:0]  primed;
    logic        armed;
    logic        sclk_rise, sclk_fall, ss_rise, ss_fall, mosi_bit;

    logic [2:0]  bit_cnt;
    logic [6:0]  shift_in;
    logic [7:0]  shift_out;
    logic [7:0]  rx_byte;
    logic        byte_done;
    logic [5:0]  addr;
    logic        rd_mode;
    logic [7:0]  rd_val;

    logic        cmd_done, addr_latch, load_rd, shift_rd, wr_byte;

    logic [11:0] pend_x, pend_y, pend_z;
    logic        pend_valid;
    logic [11:0] data_x, data_y, data_z;
    logic        copy;

    logic [7:0]  filter_ctl, power_ctl;

    // Synchronizers and edge detection. ss resets high so busy reads 0 in reset.
    // 'armed' is only set once ss has been seen high after the synchronizer
    // has flushed, so a reset in mid-frame never fakes an ss falling edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_s <= 2'b00;
            ss_s   <= 2'b11;
            mosi_s <= 2'b00;
            sclk_q <= 1'b0;
            ss_q   <= 1'b1;
            primed <= 2'b00;
            armed  <= 1'b0;
        end else begin
            sclk_s <= {sclk_s[0], sclk};
            ss_s   <= {ss_s[0], ss};
            mosi_s <= {mosi_s[0], mosi};
            sclk_q <= sclk_s[1];
            ss_q   <= ss_s[1];
            primed <= {primed[0], 1'b1};
            if (primed[1] && ss_s[1])
                armed <= 1'b1;
        end
    end

    assign sclk_rise = sclk_s[1] & ~sclk_q;
    assign sclk_fall = ~sclk_s[1] & sclk_q;
    assign ss_fall   = armed & ss_q & ~ss_s[1];
    assign ss_rise   = ~ss_q & ss_s[1];
    assign mosi_bit  = mosi_s[1];
    assign busy      = ~ss_s[1];

    assign rx_byte   = {shift_in, mosi_bit};
    assign byte_done = sclk_rise && (bit_cnt == 3'd7);

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (ss_fall) state_nxt = CMD;
            CMD: begin
                if (byte_done) begin
                    if (rx_byte == CMD_READ)
                        state_nxt = ADDR;
                    else if (WRITE_EN && (rx_byte == CMD_WRITE))
                        state_nxt = ADDR;
                    else
                        state_nxt = IGNORE;
                end
            end
            ADDR: if (byte_done) state_nxt = rd_mode ? RDATA : WDATA;
            default: ;
        endcase
        if ((state != IDLE) && ss_rise)
            state_nxt = IDLE;
    end

    // FSM: outputs (datapath strobes)
    always_comb begin
        cmd_done   = 1'b0;
        addr_latch = 1'b0;
        load_rd    = 1'b0;
        shift_rd   = 1'b0;
        wr_byte    = 1'b0;
        case (state)
            CMD:  cmd_done   = byte_done;
            ADDR: addr_latch = byte_done;
            RDATA: begin
                // bit_cnt is 0 only on the first falling edge after a byte boundary
                load_rd  = sclk_fall && (bit_cnt == 3'd0);
                shift_rd = sclk_fall && (bit_cnt != 3'd0);
            end
            WDATA: wr_byte = byte_done;
            default: ;
        endcase
    end

    always_comb begin
        rd_val = 8'h00;
        case (addr)
            6'h00: rd_val = DEVID_AD;
            6'h01: rd_val = DEVID_MST;
            6'h02: rd_val = PARTID;
            6'h0B: rd_val = {7'd0, data_ready};
            6'h0E: rd_val = data_x[7:0];
            6'h0F: rd_val = {{4{data_x[11]}}, data_x[11:8]};
            6'h10: rd_val = data_y[7:0];
            6'h11: rd_val = {{4{data_y[11]}}, data_y[11:8]};
            6'h12: rd_val = data_z[7:0];
            6'h13: rd_val = {{4{data_z[11]}}, data_z[11:8]};
            6'h2C: rd_val = filter_ctl;
            6'h2D: rd_val = power_ctl;
            default: rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt   <= 3'd0;
            shift_in  <= 7'd0;
            shift_out <= 8'd0;
            addr      <= 6'd0;
            rd_mode   <= 1'b0;
            miso      <= 1'b0;
        end else begin
            if (ss_fall) begin
                bit_cnt <= 3'd0;
            end else if ((state != IDLE) && sclk_rise) begin
                shift_in <= rx_byte[6:0];
                bit_cnt  <= bit_cnt + 3'd1;
            end

            if (cmd_done)
                rd_mode <= (rx_byte == CMD_READ);

            if (addr_latch)
                addr <= rx_byte[5:0];
            else if (load_rd || wr_byte)
                addr <= addr + 6'd1;

            if ((state != RDATA) || ss_rise) begin
                miso <= 1'b0;
            end else if (load_rd) begin
                miso      <= rd_val[7];
                shift_out <= {rd_val[6:0], 1'b0};
            end else if (shift_rd) begin
                miso      <= shift_out[7];
                shift_out <= {shift_out[6:0], 1'b0};
            end
        end
    end

    // Sample shadowing: pending is only published while deselected so a
    // burst read always sees one coherent sample.
    assign copy = pend_valid && !busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_x     <= 12'd0;
            pend_y     <= 12'd0;
            pend_z     <= 12'd0;
            pend_valid <= 1'b0;
            data_x     <= 12'd0;
            data_y     <= 12'd0;
            data_z     <= 12'd0;
            data_ready <= 1'b0;
        end else begin
            if (sample_valid) begin
                pend_x     <= sample_x;
                pend_y     <= sample_y;
                pend_z     <= sample_z;
                pend_valid <= 1'b1;
            end else if (copy) begin
                pend_valid <= 1'b0;
            end

            if (load_rd && (addr == 6'h13))
                data_ready <= 1'b0;
            // copy takes priority over the read-side clear
            if (copy) begin
                data_x     <= pend_x;
                data_y     <= pend_y;
                data_z     <= pend_z;
                data_ready <= 1'b1;
            end
        end
    end

`ifdef ADXL_RESP_WRITE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filter_ctl       <= FILTER_CTL_RST;
            power_ctl        <= POWER_CTL_RST;
            soft_reset_pulse <= 1'b0;
        end else begin
            soft_reset_pulse <= 1'b0;
            if (wr_byte) begin
                case (addr)
                    6'h1F: begin
                        if (rx_byte == 8'h52) begin
                            soft_reset_pulse <= 1'b1;
                            filter_ctl       <= FILTER_CTL_RST;
                            power_ctl        <= POWER_CTL_RST;
                        end
                    end
                    6'h2C: filter_ctl <= rx_byte;
                    6'h2D: power_ctl  <= rx_byte;
                    default: ;
                endcase
            end
        end
    end
`else
    assign filter_ctl       = FILTER_CTL_RST;
    assign power_ctl        = POWER_CTL_RST;
    assign soft_reset_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_adxl362_spi_responder.sv
module tb_adxl362_spi_responder;

    localparam int HALF = 8;   // clk cycles per sclk half period

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk;
    logic        ss;
    logic        mosi;
    logic        miso;
    logic [11:0] sample_x, sample_y, sample_z;
    logic        sample_valid;
    logic        data_ready;
    logic        busy;
    logic        soft_reset_pulse;

    int n_total = 0;
    int n_pass  = 0;
    int pulse_cnt = 0;

    adxl362_spi_responder dut (
        .clk              (clk),
        .reset            (reset),
        .sclk             (sclk),
        .ss               (ss),
        .mosi             (mosi),
        .miso             (miso),
        .sample_x         (sample_x),
        .sample_y         (sample_y),
        .sample_z         (sample_z),
        .sample_valid     (sample_valid),
        .data_ready       (data_ready),
        .busy             (busy),
        .soft_reset_pulse (soft_reset_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (soft_reset_pulse === 1'b1) pulse_cnt++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            wait_clk(HALF);
            rx = {rx[6:0], miso};
            sclk = 1'b1;
            wait_clk(HALF);
            sclk = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        xfer_bits(tx, 8, rx);
    endtask

    task automatic frame_begin();
        ss = 1'b0;
        wait_clk(HALF);
    endtask

    task automatic frame_end();
        wait_clk(HALF);
        ss = 1'b1;
        wait_clk(2 * HALF);
    endtask

    task automatic read_check(input string tag, input logic [7:0] a, input int n,
                              input logic [7:0] exp [6]);
        logic [7:0] rx;
        frame_begin();
        xfer(8'h0B, rx);
        xfer(a, rx);
        for (int i = 0; i < n; i++) begin
            xfer(8'h00, rx);
            check($sformatf("%s[%0d]", tag, i), {24'd0, rx}, {24'd0, exp[i]});
        end
        frame_end();
    endtask

    task automatic write_frame(input logic [7:0] a, input logic [7:0] d0,
                               input int n, input logic [7:0] d1);
        logic [7:0] rx;
        frame_begin();
        xfer(8'h0A, rx);
        xfer(a, rx);
        xfer(d0, rx);
        if (n > 1) xfer(d1, rx);
        frame_end();
    endtask

    initial begin
        logic [7:0] rx;
        logic [7:0] acc;
        logic [7:0] exp_2c, exp_2d;
        int         exp_pulse;

        reset = 1'b1; ss = 1'b1; sclk = 1'b0; mosi = 1'b0;
        sample_valid = 1'b0; sample_x = 12'h0; sample_y = 12'h0; sample_z = 12'h0;
        wait_clk(4);
        check("rst_miso", {31'd0, miso}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_data_ready", {31'd0, data_ready}, 0);
        check("rst_soft_reset", {31'd0, soft_reset_pulse}, 0);
        reset = 1'b0;
        wait_clk(6);

        // ID read with busy and miso latency probes
        ss = 1'b0;
        wait_clk(1);
        check("busy_lat1", {31'd0, busy}, 0);
        wait_clk(1);
        check("busy_lat2", {31'd0, busy}, 1);
        wait_clk(HALF - 2);
        xfer(8'h0B, rx);
        xfer(8'h00, rx);
        wait_clk(2);
        check("miso_lat2", {31'd0, miso}, 0);
        wait_clk(1);
        check("miso_lat3", {31'd0, miso}, 1);
        xfer(8'h00, rx); check("id0", {24'd0, rx}, 32'hAD);
        xfer(8'h00, rx); check("id1", {24'd0, rx}, 32'h1D);
        xfer(8'h00, rx); check("id2", {24'd0, rx}, 32'hF2);
        frame_end();
        check("busy_idle", {31'd0, busy}, 0);
        check("miso_idle", {31'd0, miso}, 0);

        // Burst data read
        sample_x = 12'h123; sample_y = 12'hF80; sample_z = 12'h7FF;
        sample_valid = 1'b1; wait_clk(1); sample_valid = 1'b0;
        wait_clk(4);
        check("dr_after_sample", {31'd0, data_ready}, 1);
        frame_begin();
        xfer(8'h0B, rx);
        xfer(8'h0E, rx);
        xfer(8'h00, rx); check("burst0", {24'd0, rx}, 32'h23);
        xfer(8'h00, rx); check("burst1", {24'd0, rx}, 32'h01);
        xfer(8'h00, rx); check("burst2", {24'd0, rx}, 32'h80);
        xfer(8'h00, rx); check("burst3", {24'd0, rx}, 32'hFF);
        check("dr_mid_burst", {31'd0, data_ready}, 1);
        xfer(8'h00, rx); check("burst4", {24'd0, rx}, 32'hFF);
        xfer(8'h00, rx); check("burst5", {24'd0, rx}, 32'h07);
        wait_clk(4);
        check("dr_after_zh", {31'd0, data_ready}, 0);
        frame_end();

        // Coherency: new sample mid-burst must not leak into this burst
        frame_begin();
        xfer(8'h0B, rx);
        xfer(8'h0E, rx);
        xfer(8'h00, rx); check("coh0", {24'd0, rx}, 32'h23);
        xfer(8'h00, rx); check("coh1", {24'd0, rx}, 32'h01);
        sample_x = 12'h456; sample_y = 12'hABC; sample_z = 12'h001;
        sample_valid = 1'b1; wait_clk(1); sample_valid = 1'b0;
        xfer(8'h00, rx); check("coh2", {24'd0, rx}, 32'h80);
        xfer(8'h00, rx); check("coh3", {24'd0, rx}, 32'hFF);
        xfer(8'h00, rx); check("coh4", {24'd0, rx}, 32'hFF);
        xfer(8'h00, rx); check("coh5", {24'd0, rx}, 32'h07);
        wait_clk(4);
        check("coh_dr_held", {31'd0, data_ready}, 0);
        frame_end();
        check("coh_dr_after", {31'd0, data_ready}, 1);
        read_check("new", 8'h0E, 6, '{8'h56, 8'h04, 8'hBC, 8'hFA, 8'h01, 8'h00});

        // Address wrap and unknown command
        read_check("wrap", 8'h3F, 2, '{8'h00, 8'hAD, 8'h00, 8'h00, 8'h00, 8'h00});
        frame_begin();
        acc = 8'h00;
        xfer(8'h55, rx); acc = acc | rx;
        xfer(8'h00, rx); acc = acc | rx;
        xfer(8'hFF, rx); acc = acc | rx;
        xfer(8'h00, rx); acc = acc | rx;
        check("unknown_miso", {24'd0, acc}, 0);
        frame_end();

        // Writes: burst 0x2C/0x2D then soft reset
`ifdef ADXL_RESP_WRITE_EN
        exp_2c = 8'h55; exp_2d = 8'h02; exp_pulse = 1;
`else
        exp_2c = 8'h13; exp_2d = 8'h00; exp_pulse = 0;
`endif
        write_frame(8'h2C, 8'h55, 2, 8'h02);
        read_check("wr_ctl", 8'h2C, 2, '{exp_2c, exp_2d, 8'h00, 8'h00, 8'h00, 8'h00});
        check("pulse_before", pulse_cnt, 0);
        write_frame(8'h1F, 8'h52, 1, 8'h00);
        check("pulse_count", pulse_cnt, exp_pulse);
        read_check("post_srst", 8'h2C, 2, '{8'h13, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

        // Abort by ss mid address, then reset mid data byte
        frame_begin();
        xfer(8'h0B, rx);
        xfer_bits(8'h0E, 5, rx);
        wait_clk(HALF);
        ss = 1'b1;
        wait_clk(2 * HALF);
        check("abort_ss_miso", {31'd0, miso}, 0);

        frame_begin();
        xfer(8'h0B, rx);
        xfer(8'h00, rx);
        xfer_bits(8'h00, 3, rx);
        check("pre_reset_bits", {24'd0, rx}, 32'h05);
        reset = 1'b1;
        wait_clk(3);
        check("reset_miso", {31'd0, miso}, 0);
        reset = 1'b0;
        xfer_bits(8'h00, 5, rx);
        check("post_reset_bits", {24'd0, rx}, 0);
        xfer(8'h00, rx);
        check("post_reset_byte", {24'd0, rx}, 0);
        check("post_reset_miso", {31'd0, miso}, 0);
        frame_end();
        read_check("after_abort", 8'h00, 1, '{8'hAD, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
